// File: rtl/if_id_buf_pkg.sv
// Shared constants and types for the fetch/decode instruction buffer.
package if_id_buf_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] INST_NOP = 32'h00000013;  // addi x0,x0,0
  localparam logic [DATA_WIDTH-1:0] ZERO     = '0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/if_id_buf_inst_fifo_mem.sv
// Register array holding {pc, inst} fetch entries; synchronous write, async read.
module inst_fifo_mem
  import if_id_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);
  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we == WRITE_ENABLE) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_buf.sv
// Fetch->decode instruction FIFO; presents a NOP to decode when empty or flushed.
// Optional decode-stall counter enabled by defining IF_ID_STALL_CNT_EN.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
`ifdef IF_ID_STALL_CNT_EN
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  if_valid_i,
  output logic                  if_ready_o,
  input  logic [DATA_WIDTH-1:0] if_inst_i,
  input  logic [DATA_WIDTH-1:0] if_pc_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] inst_addr_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_WIDTH < 1) begin : g_bad_param
    $error("if_id_buf: DEPTH must be a power of two >= 2 and CNT_WIDTH >= 1");
  end

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  fetch_entry_t  head;

  // Ready depends on occupancy only, so a full buffer never passes through.
  assign if_ready_o = (count != CNT_FULL);
  assign id_valid_o = (count != '0);
  assign push       = if_valid_i & if_ready_o & ~flush_i;
  assign pop        = id_valid_o & id_ready_i & ~flush_i;

  inst_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push ? WRITE_ENABLE : ~WRITE_ENABLE),
    .waddr (wr_ptr),
    .wdata ('{pc: if_pc_i, inst: if_inst_i}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign inst_o      = id_valid_o ? head.inst : INST_NOP;
  assign inst_addr_o = id_valid_o ? head.pc   : ZERO;

`ifdef IF_ID_STALL_CNT_EN
  // Saturating: sticks at all-ones until the next reset.
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt_o <= '0;
    else if (id_valid_o && !id_ready_i && !flush_i && stall_cnt_o != '1)
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end
`endif
endmodule
